usr_param: RTL and testbench

Parametrised universal shift register, the successor to the fixed 16-bit universal shift register. It adds a configurable width, an arithmetic-shift mode and an optional rotate mode. Shifts are multi-bit commands that take a start/busy/done handshake and move one bit per cycle. It is a building block for serialisers, bit-serial arithmetic and test-pattern generation.

---
 rtl/usr_pkg.sv | 39 +++
 rtl/usr_step.sv | 40 ++++
 rtl/usr_param.sv | 145 ++++++++++++++
 tb/tb_usr_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the parametrised universal shift register:
//   - 3-bit operation codes (MODE_*)
//   - FSM state encoding (ST_IDLE, ST_SHIFT)
//   - is_shift_mode(): tells whether a code starts a multi-cycle shift
// Configuration macro: USR_ROTATE_EN (enables ROR/ROL as shift modes).
// ----------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Codes that enter SHIFT when amt >= 1. Without rotate support the
    // rotate codes fall through to the reserved/HOLD behaviour.
    function automatic logic is_shift_mode(input logic [2:0] m);
        logic r;
        case (m)
            MODE_SHR, MODE_SHL, MODE_ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
            MODE_ROR, MODE_ROL:           r = 1'b1;
`endif
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_step.sv
// ----------------------------------------------------------------------------
// usr_step
// Combinational single-bit step of the universal shift register.
// Ports:
//   mode      in  3      operation code (usr_pkg MODE_*)
//   cur       in  WIDTH  current register value
//   right_in  in  1      fill bit for the MSB on SHR
//   left_in   in  1      fill bit for the LSB on SHL
//   next      out WIDTH  value after one step (cur for non-shift codes)
// Configuration macro: USR_ROTATE_EN -- when undefined the rotate datapath
// is not built and ROR/ROL codes leave the value unchanged.
// ----------------------------------------------------------------------------
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] cur,
    input  logic             right_in,
    input  logic             left_in,
    output logic [WIDTH-1:0] next
);

    // One-bit shift/rotate selected by the operation code
    always_comb begin
        next = cur;
        case (mode)
            MODE_SHR: next = {right_in, cur[WIDTH-1:1]};
            MODE_SHL: next = {cur[WIDTH-2:0], left_in};
`ifdef USR_ROTATE_EN
            MODE_ROR: next = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL: next = {cur[WIDTH-2:0], cur[WIDTH-1]};
`endif
            MODE_ASR: next = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:  next = cur;
        endcase
    end

endmodule

// File: rtl/usr_param.sv
// ----------------------------------------------------------------------------
// usr_param
// Parametrised universal shift register with multi-bit shift commands.
// A command is strobed with start while idle; shifts move one bit per cycle
// with busy high, and every command ends with a one-cycle done pulse.
// Ports:
//   clk        in  1      rising-edge clock
//   clr        in  1      synchronous active-high clear (highest priority)
//   start      in  1      command strobe, sampled only when idle
//   mode       in  3      operation code (usr_pkg MODE_*)
//   amt        in  AMT_W  shift count, saturates at WIDTH
//   right_in   in  1      MSB fill for SHR, sampled at every step
//   left_in    in  1      LSB fill for SHL, sampled at every step
//   par_in     in  WIDTH  parallel load data
//   out        out WIDTH  register contents
//   ser_out_r  out 1      out[0]
//   ser_out_l  out 1      out[WIDTH-1]
//   busy       out 1      multi-cycle shift in progress
//   done       out 1      command-complete pulse
// Configuration macro: USR_ROTATE_EN (ROR/ROL available when defined).
// ----------------------------------------------------------------------------
module usr_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             right_in,
    input  logic             left_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       mode_q,  mode_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [AMT_W-1:0] amt_sat;
    logic [WIDTH-1:0] step_next;

    // Clamp the requested count so no more than WIDTH steps are ever taken
    always_comb begin
        if (amt > AMT_MAX) begin
            amt_sat = AMT_MAX;
        end else begin
            amt_sat = amt;
        end
    end

    // The step always uses the latched mode so mode changes while busy are ignored
    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode     (mode_q),
        .cur      (out_q),
        .right_in (right_in),
        .left_in  (left_in),
        .next     (step_next)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_LOAD) begin
                        out_d  = par_in;
                        done_d = 1'b1;
                    end else if (is_shift_mode(mode) && (amt != '0)) begin
                        mode_d  = mode;
                        cnt_d   = amt_sat;
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        // HOLD, reserved, disabled rotate, or zero count
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                out_d = step_next;
                cnt_d = cnt_q - AMT_ONE;
                if (cnt_q == AMT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign ser_out_r = out_q[0];
    assign ser_out_l = out_q[WIDTH-1];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_usr_param.sv
// ----------------------------------------------------------------------------
// tb_usr_param
// Scoreboard bench for usr_param (WIDTH=16). Stimulus pushes the expected
// register value and done cycle for each command; a monitor pops and checks
// on every done pulse. Honours USR_ROTATE_EN for the rotate expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usr_param;
    import usr_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  mode;
    logic [4:0]  amt;
    logic        right_in;
    logic        left_in;
    logic [15:0] par_in;
    logic [15:0] dout;
    logic        ser_out_r;
    logic        ser_out_l;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    usr_param #(.WIDTH(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mode      (mode),
        .amt       (amt),
        .right_in  (right_in),
        .left_in   (left_in),
        .par_in    (par_in),
        .out       (dout),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding command
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_out"}, 32'(dout), 32'(e.val));
                chk({e.name, "_done_cyc"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_ser_r"}, 32'(ser_out_r), 32'(e.val[0]));
                chk({e.name, "_ser_l"}, 32'(ser_out_l), 32'(e.val[15]));
            end
        end
    end

    // Issue one command, push its expectation, count busy cycles until done.
    // b2b=1 issues in the current (done) cycle without waiting a negedge.
    task automatic run_cmd(input string nm, input logic [2:0] m, input logic [4:0] a,
                           input logic [15:0] p, input logic ri, input logic li,
                           input logic [15:0] ev, input int k, input bit b2b);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        if (!b2b) @(negedge clk);
        mode     = m;
        amt      = a;
        par_in   = p;
        right_in = ri;
        left_in  = li;
        start    = 1'b1;
        e.val    = ev;
        e.cyc    = cyc + 1 + k;
        e.name   = nm;
        sb_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        chk({nm, "_finished"}, 32'(seen), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(k));
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        mode     = MODE_HOLD;
        amt      = 5'd0;
        right_in = 1'b0;
        left_in  = 1'b0;
        par_in   = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ser_r", 32'(ser_out_r), 32'h0);
        chk("rst_ser_l", 32'(ser_out_l), 32'h0);
        clr = 1'b0;

        run_cmd("load_a5c3", MODE_LOAD, 5'd0, 16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 0, 1'b0);
        run_cmd("load_00f0", MODE_LOAD, 5'd0, 16'h00F0, 1'b0, 1'b0, 16'h00F0, 0, 1'b0);
        run_cmd("shr4",      MODE_SHR,  5'd4, 16'hFFFF, 1'b1, 1'b0, 16'hF00F, 4, 1'b0);
        run_cmd("load_8010", MODE_LOAD, 5'd0, 16'h8010, 1'b0, 1'b0, 16'h8010, 0, 1'b0);
        run_cmd("asr3",      MODE_ASR,  5'd3, 16'h0000, 1'b0, 1'b0, 16'hF002, 3, 1'b0);
        run_cmd("shl20_sat", MODE_SHL,  5'd20, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16, 1'b0);
        run_cmd("load_1234", MODE_LOAD, 5'd0, 16'h1234, 1'b0, 1'b0, 16'h1234, 0, 1'b0);
`ifdef USR_ROTATE_EN
        run_cmd("rol4",      MODE_ROL,  5'd4, 16'h0000, 1'b0, 1'b0, 16'h2341, 4, 1'b0);
        run_cmd("ror4",      MODE_ROR,  5'd4, 16'h0000, 1'b0, 1'b0, 16'h1234, 4, 1'b0);
`else
        run_cmd("rol4_off",  MODE_ROL,  5'd4, 16'h0000, 1'b0, 1'b0, 16'h1234, 0, 1'b0);
        run_cmd("ror4_off",  MODE_ROR,  5'd4, 16'h0000, 1'b0, 1'b0, 16'h1234, 0, 1'b0);
`endif
        run_cmd("hold5",     MODE_HOLD, 5'd5, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 0, 1'b0);
        run_cmd("shr_amt0",  MODE_SHR,  5'd0, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 0, 1'b0);
        run_cmd("rsvd3",     MODE_RSVD, 5'd3, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 0, 1'b0);

        // Busy robustness: LOAD during shift ignored, clr mid-shift aborts silently
        @(negedge clk);
        mode     = MODE_SHR;
        amt      = 5'd8;
        right_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);                       // after edge 0
        start = 1'b0;
        @(negedge clk);                       // after edge 1
        @(negedge clk);                       // after edge 2
        mode   = MODE_LOAD;
        par_in = 16'hFFFF;
        start  = 1'b1;
        @(negedge clk);                       // after edge 3
        start = 1'b0;
        mode  = MODE_SHR;
        @(negedge clk);                       // after edge 4
        chk("robust_out_step4", 32'(dout), 32'h0123);
        chk("robust_busy_step4", 32'(busy), 32'h1);
        clr = 1'b1;
        @(negedge clk);                       // after edge 5
        chk("clr_out", 32'(dout), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_done", 32'(done), 32'h0);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_busy_later", 32'(busy), 32'h0);

        // Back-to-back: second command issued in the done cycle of the first
        run_cmd("load_8421", MODE_LOAD, 5'd0, 16'h8421, 1'b0, 1'b0, 16'h8421, 0, 1'b0);
        run_cmd("b2b_shr1",  MODE_SHR,  5'd1, 16'h0000, 1'b0, 1'b0, 16'h4210, 1, 1'b0);
        run_cmd("b2b_shl1",  MODE_SHL,  5'd1, 16'h0000, 1'b0, 1'b0, 16'h8420, 1, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
